// File: rtl/regfile_pkg.sv
// Shared constants for the architectural register file.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    // X31 is the hardwired zero register, so only X0..X30 have storage.
    localparam int NUM_PHYS = NUM_REGS - 1;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

endpackage : regfile_pkg

// File: rtl/decoder5to32.sv
// 5:32 one-hot decoder with an enable; all outputs low when disabled.
module decoder5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // One-hot decode of addr, gated by en.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : decoder5to32

// File: rtl/mux32to1.sv
// Single-bit 32:1 multiplexer; one instance per data bit per read port.
module mux32to1
    import regfile_pkg::*;
(
    input  logic [NUM_REGS-1:0] muxIn,
    input  logic [ADDR_W-1:0]   sel,
    output logic                out
);

    // Plain indexed select; every 5-bit value is a legal index.
    always_comb begin
        out = muxIn[sel];
    end

endmodule : mux32to1

// File: rtl/reg_file.sv
// Architectural register file: 31 stored registers plus hardwired-zero X31,
// one synchronous write port and two combinational read ports with optional
// same-cycle write forwarding.
module reg_file
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeRegister,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] readRegister1,
    input  logic [ADDR_W-1:0] readRegister2,
    output logic [WIDTH-1:0]  readData1,
    output logic [WIDTH-1:0]  readData2
);

    logic [WIDTH-1:0]    regs [NUM_PHYS];
    logic [NUM_REGS-1:0] dec;
    logic [NUM_PHYS-1:0] wr_en;
    logic [WIDTH-1:0]    mux_data1;
    logic [WIDTH-1:0]    mux_data2;
    logic                byp1;
    logic                byp2;

    decoder5to32 u_wr_dec (
        .addr   (writeRegister),
        .en     (regWrite),
        .onehot (dec)
    );

    // Decoder output 31 has no register behind it, so writes to X31 vanish.
    assign wr_en = dec[NUM_PHYS-1:0];

    // Register storage: synchronous clear wins over any simultaneous write.
    always_ff @(posedge clk) begin
        // NOTE: the storage is ordinary flops, not a RAM macro, so clearing
        // the whole array on reset is legal and cheap to express here.
        if (reset) begin
            for (int r = 0; r < NUM_PHYS; r++) begin
                // NOTE: non-blocking assignment for all clocked state so every
                // flop samples pre-edge values regardless of statement order.
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_PHYS; r++) begin
                if (wr_en[r]) begin
                    regs[r] <= writeData;
                end
            end
        end
    end

    // Per-bit read muxes; bit b of every register feeds slice b, index 31 is 0.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_REGS-1:0] col;

        for (genvar r = 0; r < NUM_PHYS; r++) begin : g_col
            assign col[r] = regs[r][b];
        end
        assign col[NUM_REGS-1] = 1'b0;

        mux32to1 u_mux1 (
            .muxIn (col),
            .sel   (readRegister1),
            .out   (mux_data1[b])
        );

        mux32to1 u_mux2 (
            .muxIn (col),
            .sel   (readRegister2),
            .out   (mux_data2[b])
        );
    end

    // Forwarding condition per port. dec[ZERO_REG] is high exactly when a
    // write targets X31, and an address match then implies a read of X31.
    always_comb begin
        byp1 = (BYPASS != 0) && !reset && !dec[ZERO_REG]
               && regWrite && (writeRegister == readRegister1);
        byp2 = (BYPASS != 0) && !reset && !dec[ZERO_REG]
               && regWrite && (writeRegister == readRegister2);
    end

    // Output select: forwarded write data or stored state.
    always_comb begin
        readData1 = byp1 ? writeData : mux_data1;
        readData2 = byp2 ? writeData : mux_data2;
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file. Two instances share all inputs:
// u_dut0 without forwarding, u_dut1 with forwarding.
module tb_reg_file;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         regWrite;
    logic [4:0]   writeRegister;
    logic [W-1:0] writeData;
    logic [4:0]   readRegister1;
    logic [4:0]   readRegister2;
    logic [W-1:0] rd1_0, rd2_0, rd1_1, rd2_1;

    int checks   = 0;
    int failures = 0;

    reg_file #(.WIDTH(W), .BYPASS(0)) u_dut0 (
        .clk           (clk),
        .reset         (reset),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .readData1     (rd1_0),
        .readData2     (rd2_0)
    );

    reg_file #(.WIDTH(W), .BYPASS(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .readData1     (rd1_1),
        .readData2     (rd2_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance past one rising edge and settle before the next drive/sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        regWrite      = 1'b0;
        writeRegister = '0;
        writeData     = '0;
        readRegister1 = '0;
        readRegister2 = '0;

        // Reset for one edge, then sweep every address on both ports.
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            readRegister2 = 5'(31 - i);
            #1;
            check($sformatf("reset_b0_p1_x%0d", i), rd1_0, '0);
            check($sformatf("reset_b0_p2_x%0d", 31 - i), rd2_0, '0);
            check($sformatf("reset_b1_p1_x%0d", i), rd1_1, '0);
            check($sformatf("reset_b1_p2_x%0d", 31 - i), rd2_1, '0);
        end

        // Write X5 and read it back; neighbours stay zero.
        regWrite      = 1'b1;
        writeRegister = 5'd5;
        writeData     = 64'hDEADBEEF_CAFEF00D;
        tick();
        regWrite      = 1'b0;
        readRegister1 = 5'd5;
        readRegister2 = 5'd4;
        #1;
        check("wr_x5_b0", rd1_0, 64'hDEADBEEF_CAFEF00D);
        check("wr_x5_b1", rd1_1, 64'hDEADBEEF_CAFEF00D);
        check("x4_zero", rd2_0, '0);
        readRegister1 = 5'd6;
        readRegister2 = 5'd5;
        #1;
        check("x6_zero", rd1_0, '0);
        check("wr_x5_p2", rd2_0, 64'hDEADBEEF_CAFEF00D);

        // Write X31: never bypassed, never stored.
        regWrite      = 1'b1;
        writeRegister = 5'd31;
        writeData     = 64'hFFFF_FFFF_FFFF_FFFF;
        readRegister1 = 5'd31;
        readRegister2 = 5'd31;
        #1;
        check("x31_samecyc_b1_p1", rd1_1, '0);
        check("x31_samecyc_b1_p2", rd2_1, '0);
        check("x31_samecyc_b0_p1", rd1_0, '0);
        tick();
        regWrite = 1'b0;
        #1;
        check("x31_after_b0_p1", rd1_0, '0);
        check("x31_after_b0_p2", rd2_0, '0);
        check("x31_after_b1_p1", rd1_1, '0);
        check("x31_after_b1_p2", rd2_1, '0);

        // Write disabled: X7 stays zero.
        regWrite      = 1'b0;
        writeRegister = 5'd7;
        writeData     = 64'h1234;
        readRegister1 = 5'd7;
        #1;
        check("nowr_x7_samecyc_b1", rd1_1, '0);
        tick();
        check("nowr_x7_b0", rd1_0, '0);
        check("nowr_x7_b1", rd1_1, '0);

        // X9: old value A, then same-cycle write of B.
        regWrite      = 1'b1;
        writeRegister = 5'd9;
        writeData     = 64'hA;
        tick();
        writeData     = 64'hB;
        readRegister1 = 5'd9;
        readRegister2 = 5'd9;
        #1;
        check("x9_pre_b0_p1", rd1_0, 64'hA);
        check("x9_pre_b0_p2", rd2_0, 64'hA);
        check("x9_pre_b1_p1", rd1_1, 64'hB);
        check("x9_pre_b1_p2", rd2_1, 64'hB);
        tick();
        regWrite = 1'b0;
        #1;
        check("x9_post_b0_p1", rd1_0, 64'hB);
        check("x9_post_b0_p2", rd2_0, 64'hB);
        check("x9_post_b1_p1", rd1_1, 64'hB);

        // Independent ports on different registers.
        readRegister1 = 5'd5;
        readRegister2 = 5'd9;
        #1;
        check("indep_p1", rd1_0, 64'hDEADBEEF_CAFEF00D);
        check("indep_p2", rd2_0, 64'hB);

        // Fill X0..X30 (and attempt X31) with distinct values.
        regWrite = 1'b1;
        for (int i = 0; i < 32; i++) begin
            writeRegister = 5'(i);
            writeData     = 64'h1000 + 64'(i);
            tick();
        end
        regWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            readRegister2 = 5'(i);
            #1;
            check($sformatf("fill_b0_x%0d", i), rd1_0,
                  (i == 31) ? 64'h0 : 64'h1000 + 64'(i));
            check($sformatf("fill_b1_x%0d", i), rd2_1,
                  (i == 31) ? 64'h0 : 64'h1000 + 64'(i));
        end

        // Reset together with a write to X3: no forwarding, write discarded.
        reset         = 1'b1;
        regWrite      = 1'b1;
        writeRegister = 5'd3;
        writeData     = 64'h55;
        readRegister1 = 5'd3;
        readRegister2 = 5'd3;
        #1;
        check("rstwr_samecyc_b1", rd1_1, 64'h1003);
        check("rstwr_samecyc_b0", rd1_0, 64'h1003);
        tick();
        reset    = 1'b0;
        regWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            readRegister2 = 5'(i);
            #1;
            check($sformatf("rstmid_b0_x%0d", i), rd1_0, '0);
            check($sformatf("rstmid_b1_x%0d", i), rd2_1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

Architectural register storage for the datapath: 32 registers of `WIDTH` bits, one synchronous write port and two asynchronous read ports. Read selection uses per-bit `mux32to1` slices indexed by the 5-bit read address. X31 is the hardwired zero register. The block sits between instruction decode, which supplies the addresses, and the ALU operand path, which consumes `readData1` and `readData2`.

## Interface
- `WIDTH`, default 64: register and data width in bits.
- `BYPASS`, default 0: 1 routes same-cycle write data to the read ports; 0 means reads show stored state only.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous and active-high; sampled on the rising edge of `clk`.
- `regWrite`  in  1: write enable.
- `writeRegister`  in  5: write address.
- `writeData`  in  `WIDTH`: write data.
- `readRegister1`  in  5: read port 1 address.
- `readRegister2`  in  5: read port 2 address.
- `readData1`  out  `WIDTH`: read port 1 data, combinational.
- `readData2`  out  `WIDTH`: read port 2 data, combinational.

## Operation
- **Storage.** 31 physical registers, X0 to X30. X31 has no storage: it always reads 0 and ignores writes.
- **Reset.** A rising edge with `reset`=1 clears X0 to X30 to 0. Reset overrides any simultaneous write.
- **Write.**
  - Occurs on a rising edge when `reset`=0, `regWrite`=1 and `writeRegister`≠31.
  - Stores `writeData` into the addressed register.
  - All other registers hold their values.
- **Write decode.** 5:32 one-hot decode of `writeRegister`, gated by `regWrite`. Decoder output 31 is unused.
- **Read.**
  - `readDataN` = contents of register[`readRegisterN`], or 0 when the address is 31.
  - Purely combinational, with no clock involvement.
  - Both ports are independent and may address the same register.
- **Bypass when `BYPASS`=1.**
  - Condition: `regWrite`=1, `reset`=0, `writeRegister`=`readRegisterN` and `readRegisterN`≠31.
  - When the condition holds, `readDataN` = `writeData` in the same cycle.
  - Otherwise the port reads stored state.
- **Bypass when `BYPASS`=0.** No forwarding. A same-cycle read of the register being written returns the old value until the edge.
- **Address width.** All 5-bit address values are legal, so there is no out-of-range case.

## Timing
- **Write latency.** 1 edge. Data written at edge k is visible on the read ports immediately after edge k, or in cycle k-1 when `BYPASS`=1.
- **Read latency.** 0 cycles, combinational from address, register state and (when `BYPASS`=1) the write inputs.
- **Reset values.**
  - All registers are 0 after the reset edge, so `readData1` and `readData2` are 0 after reset for every address.
  - Before the first reset edge, register contents are undefined and outputs for X0 to X30 are X.
- **Reset mid-operation.** A write presented in the same cycle as `reset`=1 is discarded. The register reads 0 afterwards.
- **Writes to X31.** A write to X31 with `regWrite`=1 produces no state change and no bypass.

## Structure
- The shared package `regfile_pkg` holds:
  - `ADDR_W` = 5
  - `NUM_REGS` = 32
  - `ZERO_REG` = 5'd31
- Sub-modules:
  - `decoder5to32`: a 5-bit address plus enable in, a 32-bit one-hot enable out. This is the natural separate sub-module.
  - `mux32to1`: instantiated `WIDTH` times per read port, with bit b of all 32 register outputs as its `muxIn`. Index 31 is tied to 0.
- Register bits are plain enabled D flip-flops with synchronous clear.

## Test plan
- **Reset.** Assert `reset` for 1 edge, then sweep `readRegister1` and `readRegister2` over 0 to 31 → every read returns 0.
- **Write then read.** Write 64'hDEADBEEF_CAFEF00D to X5 at edge k → `readData1`=that value after edge k with `readRegister1`=5; X4 and X6 still 0.
- **Zero register.** Write 64'hFFFF_FFFF_FFFF_FFFF to X31 → `readData1` and `readData2` with address 31 read 0. With `BYPASS`=1 they also read 0 in the write cycle.
- **Write disabled.** `regWrite`=0 with `writeRegister`=7 and `writeData`=64'h1234 → X7 remains 0 after the edge.
- **Same-cycle read/write of X9 (old value 64'hA, new value 64'hB).** `BYPASS`=0 → `readData1`=64'hA before the edge and 64'hB after. `BYPASS`=1 → 64'hB in the same cycle. Both ports addressing X9 show identical values.
- **Reset mid-operation.** Registers X0 to X30 hold distinct values. Assert `reset`=1 together with `regWrite`=1, `writeRegister`=3, `writeData`=64'h55 → after the edge every register, X3 included, reads 0.
